// File: rtl/pipeline_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stage_reg_pkg
// Brief    : Shared state encoding, NOP encoding and per-stage payload layout
//            for the inter-stage pipeline registers.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_stage_reg_pkg;

    typedef logic [1:0] state_t;

    // Encoding equals the number of entries held, so occupancy is the state.
    localparam state_t c_st_empty = 2'd0;
    localparam state_t c_st_full  = 2'd1;
    localparam state_t c_st_skid  = 2'd2;

    localparam logic [15:0] c_nop_ir = 16'hF000;

    localparam int c_w_ir    = 16;
    localparam int c_w_pc    = 16;
    localparam int c_w_pcinc = 16;
    localparam int c_w_alu   = 16;
    localparam int c_w_ccr   = 2;

    localparam int c_off_ir    = 0;
    localparam int c_off_pc    = c_off_ir + c_w_ir;
    localparam int c_off_pcinc = c_off_pc + c_w_pc;
    localparam int c_off_alu   = c_off_pcinc + c_w_pcinc;
    localparam int c_off_ccr   = c_off_alu + c_w_alu;

    localparam int c_w_if_id  = c_w_pcinc + c_w_pc + c_w_ir;
    localparam int c_w_id_rr  = c_w_if_id;
    localparam int c_w_rr_ex  = c_w_if_id;
    localparam int c_w_ex_mem = c_w_if_id + c_w_alu + c_w_ccr;
    localparam int c_w_mem_wb = c_w_ex_mem;

endpackage : pipeline_stage_reg_pkg
`default_nettype wire

// File: rtl/pipeline_stage_reg_pipe_data_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_data_reg
// Brief    : Load-enabled payload register with synchronous active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_data_reg #(
    parameter int               WIDTH       = 48,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             i_clr_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_q <= CLEAR_VALUE;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : pipe_data_reg
`default_nettype wire

// File: rtl/pipeline_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stage_reg
// Brief    : Valid/ready inter-stage register with flush, optional skid entry
//            and saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_stage_reg
    import pipeline_stage_reg_pkg::*;
#(
    parameter int               WIDTH        = 48,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = {WIDTH{1'b0}},
    parameter int               SKID         = 1,
    parameter int               CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 flush,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_in_xfer;
    logic                 w_out_xfer;
    logic                 w_main_load;
    logic                 w_skid_load;
    logic                 w_clr_n;
    logic [WIDTH-1:0]     w_main_d;
    logic [WIDTH-1:0]     w_skid_q;
    logic [CNT_WIDTH-1:0] r_stall;

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;
    assign w_clr_n    = reset & ~flush;
    assign out_valid  = (r_state != c_st_empty);
    assign occupancy  = r_state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_st_empty;
        end else if (flush) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_load = 1'b0;
        w_main_d    = in_data;
        w_skid_load = 1'b0;
        case (r_state)
            c_st_empty: begin
                if (w_in_xfer) begin
                    w_main_load = 1'b1;
                    w_state_nxt = c_st_full;
                end
            end
            c_st_full: begin
                if (w_out_xfer && w_in_xfer) begin
                    w_main_load = 1'b1;
                end else if (w_out_xfer) begin
                    w_main_load = 1'b1;
                    w_main_d    = BUBBLE_VALUE;
                    w_state_nxt = c_st_empty;
                end else if (w_in_xfer) begin
                    // Only reachable with a skid entry: without one, in_ready
                    // is low whenever FULL and not draining.
                    w_skid_load = 1'b1;
                    w_state_nxt = c_st_skid;
                end
            end
            c_st_skid: begin
                if (out_ready) begin
                    w_main_load = 1'b1;
                    w_main_d    = w_skid_q;
                    w_state_nxt = c_st_full;
                end
            end
            default: begin
                w_state_nxt = c_st_empty;
            end
        endcase
    end

    pipe_data_reg #(
        .WIDTH       (WIDTH),
        .CLEAR_VALUE (BUBBLE_VALUE)
    ) u_main (
        .clk     (clk),
        .i_clr_n (w_clr_n),
        .i_load  (w_main_load),
        .i_d     (w_main_d),
        .o_q     (out_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic r_in_ready;

            pipe_data_reg #(
                .WIDTH       (WIDTH),
                .CLEAR_VALUE (BUBBLE_VALUE)
            ) u_skid (
                .clk     (clk),
                .i_clr_n (w_clr_n),
                .i_load  (w_skid_load),
                .i_d     (in_data),
                .o_q     (w_skid_q)
            );

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_in_ready <= 1'b1;
                end else if (flush) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_nxt != c_st_skid);
                end
            end

            assign in_ready = r_in_ready;
        end else begin : g_noskid
            logic w_skid_load_unused;

            assign w_skid_load_unused = w_skid_load;
            assign w_skid_q           = BUBBLE_VALUE;
            assign in_ready           = ~out_valid | out_ready;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall <= {CNT_WIDTH{1'b0}};
        end else if (out_valid && !out_ready && !flush && (r_stall != c_cnt_max)) begin
            r_stall <= r_stall + c_cnt_one;
        end
    end

    assign stall_count = r_stall;

endmodule : pipeline_stage_reg
`default_nettype wire

// File: tb/tb_pipeline_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_stage_reg
// Brief    : Three configurations of the stage register against a FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_stage_reg;

    localparam logic [47:0] c_bub1 = 48'h0000_0000_F000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [47:0] in_data = 48'h0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;

    logic        ov  [3];
    logic        ir  [3];
    logic [47:0] od  [3];
    logic [1:0]  occ [3];
    logic [15:0] sc0, sc2;
    logic [3:0]  sc1;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Model: each instance is a FIFO of capacity 2 (skid) or 1 (no skid).
    int          mocc [3];
    logic [47:0] mdat [3][2];
    int          mcnt [3];
    int          cmax  [3] = '{65535, 15, 65535};
    bit          mskid [3] = '{1'b1, 1'b1, 1'b0};
    logic [47:0] mbub  [3] = '{48'h0, c_bub1, 48'h0};

    always #5 clk = ~clk;

    pipeline_stage_reg #(.WIDTH(48), .SKID(1), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .flush(flush), .occupancy(occ[0]), .stall_count(sc0)
    );

    pipeline_stage_reg #(.WIDTH(48), .BUBBLE_VALUE(c_bub1), .SKID(1), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .flush(flush), .occupancy(occ[1]), .stall_count(sc1)
    );

    pipeline_stage_reg #(.WIDTH(48), .SKID(0), .CNT_WIDTH(16)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready),
        .out_data(od[2]), .flush(flush), .occupancy(occ[2]), .stall_count(sc2)
    );

    function automatic bit m_ready(int i);
        return mskid[i] ? (mocc[i] < 2) : (mocc[i] == 0 || out_ready);
    endfunction

    always @(posedge clk) begin
        bit mv, mr;
        for (int i = 0; i < 3; i++) begin
            mv = (mocc[i] > 0);
            mr = m_ready(i);
            if (!reset) begin
                mocc[i] = 0;
                mcnt[i] = 0;
            end else if (flush) begin
                mocc[i] = 0;
            end else begin
                if (mv && !out_ready && mcnt[i] < cmax[i]) mcnt[i]++;
                if (mv && out_ready) begin
                    mdat[i][0] = mdat[i][1];
                    mocc[i]--;
                end
                if (in_valid && mr) begin
                    mdat[i][mocc[i]] = in_data;
                    mocc[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [68:0] act, exp;
        logic [15:0] sc;
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                sc  = (i == 0) ? sc0 : (i == 1) ? {12'h0, sc1} : sc2;
                act = {ov[i], ir[i], occ[i], sc, od[i]};
                exp = {mocc[i] > 0, m_ready(i), 2'(mocc[i]), 16'(mcnt[i]),
                       (mocc[i] > 0) ? mdat[i][0] : mbub[i]};
                vectors++;
                if (act !== exp) begin
                    miscompares++;
                    $display("FAIL model inst%0d t=%0t got {v,r,occ,cnt,data}=%h required %h",
                             i, $time, act, exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h required %h", nm, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b1; in_data = 48'h1; out_ready = 1'b0; flush = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_ov", 64'(ov[0]), 64'd0);
        chk("rst_od", 64'(od[0]), 64'd0);
        chk("rst_od_bub", 64'(od[1]), 64'(c_bub1));
        chk("rst_occ", 64'(occ[0]), 64'd0);
        chk("rst_cnt", 64'(sc0), 64'd0);
        reset = 1'b1; in_valid = 1'b0;
        #1 chk("rst_ready", 64'(ir[0]), 64'd1);

        out_ready = 1'b1; in_valid = 1'b1; in_data = 48'hA;
        tick();
        chk("stream_a", 64'(od[0]), 64'hA);
        chk("stream_occ", 64'(occ[0]), 64'd1);
        in_data = 48'hB;
        tick();
        chk("stream_b", 64'(od[0]), 64'hB);
        chk("stream_b_noskid", 64'(od[2]), 64'hB);
        in_data = 48'hC;
        tick();
        chk("stream_c", 64'(od[0]), 64'hC);
        chk("stream_cnt", 64'(sc0), 64'd0);
        in_valid = 1'b0;
        tick();
        chk("stream_empty", 64'(ov[0]), 64'd0);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 48'h11;
        tick();
        chk("fill_occ1", 64'(occ[0]), 64'd1);
        chk("noskid_stall_ready", 64'(ir[2]), 64'd0);
        in_data = 48'h22;
        tick();
        chk("fill_occ2", 64'(occ[0]), 64'd2);
        chk("fill_ready", 64'(ir[0]), 64'd0);
        chk("noskid_occ", 64'(occ[2]), 64'd1);
        in_valid = 1'b0;
        repeat (5) tick();
        chk("stall_hold", 64'(od[0]), 64'h11);
        chk("stall_cnt6", 64'(sc0), 64'd6);
        out_ready = 1'b1;
        #1 chk("noskid_comb_ready", 64'(ir[2]), 64'd1);
        tick();
        chk("drain_second", 64'(od[0]), 64'h22);
        chk("drain_occ", 64'(occ[0]), 64'd1);
        tick();
        chk("drain_empty", 64'(ov[0]), 64'd0);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 48'h44;
        tick();
        in_data = 48'h55;
        tick();
        chk("pre_flush_occ", 64'(occ[0]), 64'd2);
        in_data = 48'h33; flush = 1'b1;
        tick();
        chk("flush_ov", 64'(ov[0]), 64'd0);
        chk("flush_od", 64'(od[1]), 64'(c_bub1));
        chk("flush_occ", 64'(occ[0]), 64'd0);
        chk("flush_ready", 64'(ir[0]), 64'd1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush_no33", 64'(ov[0]), 64'd0);

        in_valid = 1'b1; in_data = 48'h66;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        chk("sat_cnt", 64'(sc1), 64'hF);
        chk("sat_data", 64'(od[1]), 64'h66);
        out_ready = 1'b1;
        tick();

        for (int n = 0; n < 2000; n++) begin
            reset     = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_data   = {$urandom(), $urandom()};
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pipeline_stage_reg
`default_nettype wire
